mul_share_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one external signed 8-bit multiplier between NREQ requesters, for example several butterfly units.
- Drives the multiplier handshake (mul_en out, mul_done/mul_product in).
- Returns each product to the granted requester with a one-cycle ack.
- Guards each transaction with a timeout so a stalled multiplier cannot hang the butterfly sequence.

---
 rtl/mul_share_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mul_share_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one external signed multiplier
// between NREQ requesters. Each grant latches the winner's operands, holds
// mul_en while waiting for mul_done (bounded by TIMEOUT cycles), and returns
// the product with a one-cycle ack to the granted requester.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | no transaction; pick next requester from ptr when arb_en is high
// S_BUSY | mul_en high, operands held, waiting for mul_done or timeout
// S_RESP | ack pulse to grant_id with rsp_product/rsp_err, advance ptr
module mul_share_arbiter #(
  parameter int NREQ    = 2,
  parameter int W       = 8,
  parameter int TIMEOUT = 15,
  parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arb_en,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_c,
  input  logic [NREQ*W-1:0] req_d,
  output logic [NREQ-1:0]   ack,
  output logic [W-1:0]      rsp_product,
  output logic              rsp_err,
  output logic [IDW-1:0]    grant_id,
  output logic              busy,
  output logic [7:0]        timeout_cnt,
  output logic              mul_en,
  output logic [W-1:0]      mul_c,
  output logic [W-1:0]      mul_d,
  input  logic              mul_done,
  input  logic [W-1:0]      mul_product
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Last wait-counter value before the transaction is aborted.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [IDW:0] NREQ_X = (IDW + 1)'(NREQ);

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [7:0]       wait_q, wait_d;

  logic [W-1:0]     mul_c_d, mul_d_d;
  logic [IDW-1:0]   grant_id_d;
  logic [W-1:0]     rsp_product_d;
  logic             rsp_err_d;
  logic [7:0]       timeout_cnt_d;

  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic [W-1:0]     gnt_c, gnt_d;
  logic [IDW-1:0]   ptr_after_grant;

  // Round-robin search: first requester at ptr, ptr+1, ... (mod NREQ).
  always_comb begin
    logic [IDW:0] cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW + 1)'(k);
      if (cand >= NREQ_X) cand = cand - NREQ_X;
      if (!gnt_found && req[cand[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDW-1:0];
      end
    end
  end

  // Operand mux for the requester selected by the search.
  always_comb begin
    gnt_c = '0;
    gnt_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        gnt_c = req_c[i*W +: W];
        gnt_d = req_d[i*W +: W];
      end
    end
  end

  // Pointer moves just past the requester being acked.
  always_comb begin
    logic [IDW:0] nxt;
    nxt = {1'b0, grant_id} + (IDW + 1)'(1);
    if (nxt >= NREQ_X) nxt = '0;
    ptr_after_grant = nxt[IDW-1:0];
  end

  // Next-state and next-register values; everything holds by default.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    wait_d        = wait_q;
    mul_c_d       = mul_c;
    mul_d_d       = mul_d;
    grant_id_d    = grant_id;
    rsp_product_d = rsp_product;
    rsp_err_d     = rsp_err;
    timeout_cnt_d = timeout_cnt;
    case (state_q)
      S_IDLE: begin
        if (arb_en && gnt_found) begin
          mul_c_d    = gnt_c;
          mul_d_d    = gnt_d;
          grant_id_d = gnt_idx;
          wait_d     = '0;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        // mul_done takes priority over a timeout landing on the same cycle.
        if (mul_done) begin
          rsp_product_d = mul_product;
          rsp_err_d     = 1'b0;
          state_d       = S_RESP;
        end else if (wait_q == TO_LAST) begin
          rsp_product_d = '0;
          rsp_err_d     = 1'b1;
          if (timeout_cnt != 8'hFF) timeout_cnt_d = timeout_cnt + 8'd1;
          state_d       = S_RESP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_RESP: begin
        ptr_d   = ptr_after_grant;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      wait_q      <= '0;
      mul_c       <= '0;
      mul_d       <= '0;
      grant_id    <= '0;
      rsp_product <= '0;
      rsp_err     <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wait_q      <= wait_d;
      mul_c       <= mul_c_d;
      mul_d       <= mul_d_d;
      grant_id    <= grant_id_d;
      rsp_product <= rsp_product_d;
      rsp_err     <= rsp_err_d;
      timeout_cnt <= timeout_cnt_d;
    end
  end

  // Handshake outputs decoded from the registered state only.
  always_comb begin
    ack = '0;
    if (state_q == S_RESP) ack = NREQ'(1) << grant_id;
    mul_en = (state_q == S_BUSY);
    busy   = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: directed steps from the test plan followed by
// randomized transactions checked against a transaction-level model
// (rotation pointer, arithmetic product, timeout tally).
module tb_mul_share_arbiter;
  localparam int NREQ = 2;
  localparam int W = 8;
  localparam int TIMEOUT = 4;
  localparam int IDW = 1;

  logic              clk;
  logic              rst;
  logic              arb_en;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_c;
  logic [NREQ*W-1:0] req_d;
  logic [NREQ-1:0]   ack;
  logic [W-1:0]      rsp_product;
  logic              rsp_err;
  logic [IDW-1:0]    grant_id;
  logic              busy;
  logic [7:0]        timeout_cnt;
  logic              mul_en;
  logic [W-1:0]      mul_c;
  logic [W-1:0]      mul_d;
  logic              mul_done;
  logic [W-1:0]      mul_product;

  int checks = 0;
  int failures = 0;
  int exp_ptr = 0;
  int exp_tcnt = 0;

  mul_share_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .arb_en(arb_en), .req(req),
    .req_c(req_c), .req_d(req_d), .ack(ack), .rsp_product(rsp_product),
    .rsp_err(rsp_err), .grant_id(grant_id), .busy(busy),
    .timeout_cnt(timeout_cnt), .mul_en(mul_en), .mul_c(mul_c),
    .mul_d(mul_d), .mul_done(mul_done), .mul_product(mul_product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mulp(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[7:0];
  endfunction

  function automatic int pick(input logic [NREQ-1:0] r);
    int i;
    for (int k = 0; k < NREQ; k++) begin
      i = (exp_ptr + k) % NREQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_ops(input int g, input logic [7:0] c, input logic [7:0] d);
    req_c[g*W +: W] = c;
    req_d[g*W +: W] = d;
  endtask

  // Called in an IDLE cycle with inputs already driven so a grant of g is due.
  // delay = BUSY cycle index on which mul_done is raised (>= TIMEOUT: never).
  task automatic run_txn(input int g, input int delay, input bit drop_en);
    logic [7:0] c, d, prod;
    bit timed;
    int nbusy;
    c = req_c[g*W +: W];
    d = req_d[g*W +: W];
    prod = mulp(c, d);
    timed = (delay > TIMEOUT - 1);
    nbusy = timed ? TIMEOUT : delay + 1;
    step();
    check("grant_busy", busy, 1);
    check("grant_id", grant_id, g);
    check("mul_c_latch", mul_c, c);
    check("mul_d_latch", mul_d, d);
    if (drop_en) arb_en = 1'b0;
    req_c = ~req_c;
    req_d = req_d ^ 16'h5A5A;
    for (int b = 0; b < nbusy; b++) begin
      check("mul_en_busy", mul_en, 1);
      check("ack_busy", ack, 0);
      mul_done = (b == delay);
      mul_product = (b == delay) ? prod : 8'($urandom);
      step();
    end
    mul_done = 1'b0;
    if (timed && exp_tcnt < 255) exp_tcnt++;
    check("resp_ack", ack, 1 << g);
    check("resp_mul_en", mul_en, 0);
    check("resp_busy", busy, 1);
    check("resp_err", rsp_err, timed);
    check("resp_product", rsp_product, timed ? 8'h00 : prod);
    check("timeout_cnt", timeout_cnt, exp_tcnt);
    check("mul_c_held", mul_c, c);
    check("mul_d_held", mul_d, d);
    exp_ptr = (g + 1) % NREQ;
    step();
    check("post_ack", ack, 0);
    check("post_busy", busy, 0);
  endtask

  initial begin
    int g;
    rst = 1'b1; arb_en = 1'b0; req = '0; req_c = '0; req_d = '0;
    mul_done = 1'b0; mul_product = '0;
    step(); step();
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_mul_en", mul_en, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_tcnt", timeout_cnt, 0);
    check("rst_product", rsp_product, 0);
    check("rst_err", rsp_err, 0);
    check("rst_mul_c", mul_c, 0);
    rst = 1'b0;

    // Single request: 3 * -4 = -12, done two cycles after mul_en rises.
    arb_en = 1'b1; req = 2'b01; set_ops(0, 8'd3, 8'hFC);
    run_txn(0, 2, 0);
    check("single_product_val", rsp_product, 8'hF4);
    req = 2'b00;
    step();

    // Contention from a fresh pointer: strict alternation.
    rst = 1'b1; step(); rst = 1'b0; exp_ptr = 0;
    req = 2'b11;
    for (int n = 0; n < 4; n++) begin
      set_ops(0, 8'(n + 5), 8'hF9);
      set_ops(1, 8'(n - 7), 8'd11);
      check("contention_model", pick(req), n % 2);
      run_txn(n % 2, 1, 0);
    end
    req = 2'b00;

    // Done on the last allowed BUSY cycle wins over the timeout.
    req = 2'b10; set_ops(1, 8'h81, 8'h7F);
    run_txn(1, TIMEOUT - 1, 0);
    // Plain timeout: mul_done never arrives.
    req = 2'b01; set_ops(0, 8'd9, 8'd9);
    run_txn(0, TIMEOUT + 5, 0);
    check("timeout_once", timeout_cnt, 1);

    // Randomized transactions against the model.
    for (int n = 0; n < 200; n++) begin
      arb_en = ($urandom_range(0, 7) != 0);
      req = NREQ'($urandom_range(0, 3));
      req_c = 16'($urandom);
      req_d = 16'($urandom);
      mul_done = 1'($urandom);
      mul_product = 8'($urandom);
      if (arb_en && req != 0) begin
        g = pick(req);
        run_txn(g, $urandom_range(0, TIMEOUT + 1), 0);
      end else begin
        step();
        check("idle_mul_en", mul_en, 0);
        check("idle_busy", busy, 0);
        check("idle_ack", ack, 0);
        mul_done = 1'b0;
      end
    end

    // Saturating timeout counter.
    arb_en = 1'b1; mul_done = 1'b0;
    for (int n = 0; n < 300; n++) begin
      req = 2'b01;
      set_ops(0, 8'(n), 8'd2);
      run_txn(0, TIMEOUT + 1, 0);
    end
    check("timeout_saturate", timeout_cnt, 255);

    // Reset mid-BUSY clears everything, including the rotation pointer.
    req = 2'b01; set_ops(0, 8'd4, 8'd4);
    step();
    check("pre_rst_mul_en", mul_en, 1);
    rst = 1'b1;
    step();
    check("midrst_mul_en", mul_en, 0);
    check("midrst_ack", ack, 0);
    check("midrst_grant_id", grant_id, 0);
    check("midrst_busy", busy, 0);
    check("midrst_tcnt", timeout_cnt, 0);
    rst = 1'b0; exp_ptr = 0; exp_tcnt = 0;
    req = 2'b11; set_ops(0, 8'd6, 8'd7); set_ops(1, 8'd8, 8'd9);
    run_txn(0, 0, 0);
    req = 2'b10; set_ops(1, 8'hF0, 8'd3);
    run_txn(1, 1, 0);

    // arb_en gating.
    arb_en = 1'b0; req = 2'b01; set_ops(0, 8'd12, 8'hFE);
    for (int n = 0; n < 10; n++) begin
      step();
      check("gate_mul_en", mul_en, 0);
      check("gate_ack", ack, 0);
    end
    arb_en = 1'b1;
    run_txn(0, 2, 1);
    req = 2'b00;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
